// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter slice: sequencer state
// encoding, read-owner tags and default controller latencies.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    A_INIT,
    A_IDLE,
    A_CMD,
    A_WAIT
  } arb_state_t;

  typedef logic [2:0] owner_t;

  localparam owner_t OWN_NONE = 3'd0;
  localparam owner_t OWN_VID  = 3'd1;
  localparam owner_t OWN_CPU  = 3'd2;
  localparam owner_t OWN_AUX  = 3'd3;
  localparam owner_t OWN_REF  = 3'd4;

  localparam int DEF_BUSY_RW    = 6;
  localparam int DEF_BUSY_REF   = 9;
  localparam int DEF_RD_LAT     = 6;
  localparam int DEF_INIT_WAIT  = 2;
  localparam int DEF_REF_PERIOD = 1350;
  localparam int DEF_REF_URGENT = 1200;

  // Width of the busy/init/read-latency counters and of the refresh counters.
  localparam int CNT_W     = 8;
  localparam int REF_CNT_W = 16;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request source: a free-running period counter raises a
// pending flag on every expiry; the flag ages while unserved and becomes
// urgent once it has waited REF_URGENT cycles. An expiry that lands while a
// refresh is already pending is dropped.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int REF_URGENT = DEF_REF_URGENT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pending,
  output logic urgent
);

  localparam logic [REF_CNT_W-1:0] PERIOD_LAST = REF_CNT_W'(REF_PERIOD - 1);
  localparam logic [REF_CNT_W-1:0] AGE_URGENT  = REF_CNT_W'(REF_URGENT);

  logic [REF_CNT_W-1:0] period_cnt;
  logic [REF_CNT_W-1:0] age_cnt;
  logic                 expire;

  assign expire = (period_cnt == PERIOD_LAST);

  // Free-running period counter, wraps to 0 after PERIOD_LAST.
  always_ff @(posedge clk) begin
    if (reset)       period_cnt <= '0;
    else if (expire) period_cnt <= '0;
    else             period_cnt <= period_cnt + 1'b1;
  end

  // Pending flag and its saturating age; a grant clear takes precedence over a coincident expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      age_cnt <= '0;
    end else if (clear) begin
      pending <= 1'b0;
      age_cnt <= '0;
    end else if (expire && !pending) begin
      pending <= 1'b1;
      age_cnt <= '0;
    end else if (pending && (age_cnt != '1)) begin
      age_cnt <= age_cnt + 1'b1;
    end
  end

  assign urgent = pending && (age_cnt >= AGE_URGENT);

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port arbiter and command sequencer for the single-bank-cycle SDRAM
// controller. One single-cycle command is issued per controller idle window;
// occupancy is tracked with fixed busy counts instead of the controller's
// busy flag. Define SDRAM_ARB_REFRESH_EN to include the internal refresh
// timer and refresh grants; without it mem_refresh stays 0.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BUSY_RW    = DEF_BUSY_RW,
  parameter int BUSY_REF   = DEF_BUSY_REF,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int INIT_WAIT  = DEF_INIT_WAIT,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int REF_URGENT = DEF_REF_URGENT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_lb_n,
  input  logic        cpu_ub_n,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [21:0] aux_addr,
  input  logic [15:0] aux_wdata,
  input  logic        aux_lb_n,
  input  logic        aux_ub_n,
  output logic        aux_ack,
  output logic        aux_rvalid,
  output logic [15:0] aux_rdata,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_we_n,
  output logic        mem_lb_n,
  output logic        mem_ub_n,
  output logic        mem_refresh,
  input  logic [15:0] mem_datar
);

  // State table
  //   A_INIT | post-reset settle, counts INIT_WAIT cycles
  //   A_IDLE | controller idle, pick a winner and register its command
  //   A_CMD  | command strobe and winner ack asserted for one cycle
  //   A_WAIT | controller busy, busy counter runs down to the next idle window

  localparam logic [CNT_W-1:0] INIT_LOAD = (INIT_WAIT > 0) ? CNT_W'(INIT_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] RW_LOAD   = CNT_W'(BUSY_RW - 1);
  localparam logic [CNT_W-1:0] REF_LOAD  = CNT_W'(BUSY_REF - 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LAT - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] busy_cnt;
  owner_t           win;
  owner_t           rd_own;
  logic [CNT_W-1:0] rd_lat;
  logic             ref_pending;
  logic             ref_urgent;

`ifdef SDRAM_ARB_REFRESH_EN
  sdram_refresh_timer #(
    .REF_PERIOD (REF_PERIOD),
    .REF_URGENT (REF_URGENT)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == A_CMD) && mem_refresh),
    .pending (ref_pending),
    .urgent  (ref_urgent)
  );
`else
  // No internal refresh source; the REF_* parameters only fold into constant-zero flags.
  assign ref_pending = 1'b0;
  assign ref_urgent  = (REF_PERIOD < 0) && (REF_URGENT < 0);
`endif

  // Fixed priority: urgent refresh > video > CPU > aux > pending refresh.
  always_comb begin
    win = OWN_NONE;
    if (ref_urgent)       win = OWN_REF;
    else if (vid_req)     win = OWN_VID;
    else if (cpu_req)     win = OWN_CPU;
    else if (aux_req)     win = OWN_AUX;
    else if (ref_pending) win = OWN_REF;
  end

  // Sequencer FSM with registered command strobes, payload and acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= A_INIT;
      busy_cnt    <= INIT_LOAD;
      mem_rd      <= 1'b0;
      mem_we_n    <= 1'b1;
      mem_refresh <= 1'b0;
      mem_lb_n    <= 1'b1;
      mem_ub_n    <= 1'b1;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      aux_ack     <= 1'b0;
    end else begin
      mem_rd      <= 1'b0;
      mem_we_n    <= 1'b1;
      mem_refresh <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      aux_ack     <= 1'b0;
      case (state)
        A_INIT: begin
          if (busy_cnt == '0) state <= A_IDLE;
          else                busy_cnt <= busy_cnt - 1'b1;
        end
        A_IDLE: begin
          state <= A_CMD;
          case (win)
            OWN_REF: mem_refresh <= 1'b1;
            OWN_VID: begin
              mem_rd   <= 1'b1;
              mem_addr <= vid_addr;
              mem_lb_n <= 1'b0;
              mem_ub_n <= 1'b0;
              vid_ack  <= 1'b1;
            end
            OWN_CPU: begin
              mem_addr <= cpu_addr;
              mem_lb_n <= cpu_lb_n;
              mem_ub_n <= cpu_ub_n;
              cpu_ack  <= 1'b1;
              if (cpu_we) begin
                mem_we_n  <= 1'b0;
                mem_wdata <= cpu_wdata;
              end else begin
                mem_rd <= 1'b1;
              end
            end
            OWN_AUX: begin
              mem_addr <= aux_addr;
              mem_lb_n <= aux_lb_n;
              mem_ub_n <= aux_ub_n;
              aux_ack  <= 1'b1;
              if (aux_we) begin
                mem_we_n  <= 1'b0;
                mem_wdata <= aux_wdata;
              end else begin
                mem_rd <= 1'b1;
              end
            end
            default: state <= A_IDLE;
          endcase
        end
        A_CMD: begin
          busy_cnt <= mem_refresh ? REF_LOAD : RW_LOAD;
          state    <= A_WAIT;
        end
        A_WAIT: begin
          busy_cnt <= busy_cnt - 1'b1;
          if (busy_cnt <= CNT_W'(1)) state <= A_IDLE;
        end
        default: state <= A_INIT;
      endcase
    end
  end

  // Read return: tag the reader in the command cycle, capture mem_datar RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_own     <= OWN_NONE;
      rd_lat     <= '0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
    end else begin
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      if ((state == A_CMD) && mem_rd) begin
        rd_lat <= RD_LOAD;
        rd_own <= vid_ack ? OWN_VID : (cpu_ack ? OWN_CPU : OWN_AUX);
      end else if (rd_own != OWN_NONE) begin
        if (rd_lat == '0) begin
          case (rd_own)
            OWN_VID: begin vid_rdata <= mem_datar; vid_rvalid <= 1'b1; end
            OWN_CPU: begin cpu_rdata <= mem_datar; cpu_rvalid <= 1'b1; end
            OWN_AUX: begin aux_rdata <= mem_datar; aux_rvalid <= 1'b1; end
            default: ;
          endcase
          rd_own <= OWN_NONE;
        end else begin
          rd_lat <= rd_lat - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter. Cycle k counts negedges after the one at
// which reset is released (cycle 0). A small controller model returns
// mem_addr[15:0]^16'hBFCC six cycles after each read strobe.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [21:0] vid_addr = '0;
  logic        vid_ack, vid_rvalid;
  logic [15:0] vid_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lb_n = 1'b0, cpu_ub_n = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        aux_req = 1'b0, aux_we = 1'b0, aux_lb_n = 1'b0, aux_ub_n = 1'b0;
  logic [21:0] aux_addr = '0;
  logic [15:0] aux_wdata = '0;
  logic        aux_ack, aux_rvalid;
  logic [15:0] aux_rdata;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd, mem_we_n, mem_lb_n, mem_ub_n, mem_refresh;
  logic [15:0] mem_datar;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .REF_PERIOD (50),
    .REF_URGENT (20)
  ) dut (
    .clk (clk), .reset (reset),
    .vid_req (vid_req), .vid_addr (vid_addr), .vid_ack (vid_ack),
    .vid_rvalid (vid_rvalid), .vid_rdata (vid_rdata),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_lb_n (cpu_lb_n), .cpu_ub_n (cpu_ub_n), .cpu_ack (cpu_ack),
    .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
    .aux_req (aux_req), .aux_we (aux_we), .aux_addr (aux_addr), .aux_wdata (aux_wdata),
    .aux_lb_n (aux_lb_n), .aux_ub_n (aux_ub_n), .aux_ack (aux_ack),
    .aux_rvalid (aux_rvalid), .aux_rdata (aux_rdata),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rd (mem_rd),
    .mem_we_n (mem_we_n), .mem_lb_n (mem_lb_n), .mem_ub_n (mem_ub_n),
    .mem_refresh (mem_refresh), .mem_datar (mem_datar)
  );

  // Controller read-data model: data appears 6 cycles after the read strobe cycle.
  logic [5:0]  rd_pipe = '0;
  logic [15:0] dat_pipe [0:5];
  always @(posedge clk) begin
    rd_pipe     <= {rd_pipe[4:0], mem_rd};
    dat_pipe[0] <= mem_addr[15:0] ^ 16'hBFCC;
    for (int i = 1; i < 6; i++) dat_pipe[i] <= dat_pipe[i-1];
  end
  assign mem_datar = rd_pipe[5] ? dat_pipe[5] : 16'h0000;

  task automatic clear_inputs();
    vid_req = 0; cpu_req = 0; aux_req = 0;
    cpu_we = 0; aux_we = 0;
    cpu_lb_n = 0; cpu_ub_n = 0; aux_lb_n = 0; aux_ub_n = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, mem_we_n, mem_refresh, mem_lb_n, mem_ub_n} !== 5'b01011) begin
      errors++; $display("FAIL reset_strobes: got %b expected 01011", {mem_rd, mem_we_n, mem_refresh, mem_lb_n, mem_ub_n});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 38'h0) begin
      errors++; $display("FAIL reset_payload: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({vid_ack, cpu_ack, aux_ack, vid_rvalid, cpu_rvalid, aux_rvalid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 000000", {vid_ack, cpu_ack, aux_ack, vid_rvalid, cpu_rvalid, aux_rvalid});
    end
    checks++;
    if ({vid_rdata, cpu_rdata, aux_rdata} !== 48'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {vid_rdata, cpu_rdata, aux_rdata});
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000123;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rd !== (k == 3)) begin
        errors++; $display("FAIL cpu_read mem_rd cyc %0d: got %b expected %b", k, mem_rd, (k == 3));
      end
      checks++;
      if (cpu_rvalid !== (k == 10)) begin
        errors++; $display("FAIL cpu_read rvalid cyc %0d: got %b expected %b", k, cpu_rvalid, (k == 10));
      end
      if (k == 3) begin
        checks++;
        if (mem_addr !== 22'h000123 || cpu_ack !== 1'b1) begin
          errors++; $display("FAIL cpu_read cmd: got addr %h ack %b expected 000123 1", mem_addr, cpu_ack);
        end
        cpu_req = 0;
      end
      if (k == 10) begin
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
          errors++; $display("FAIL cpu_read rdata: got %h expected beef", cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_vid_cpu_priority();
    do_reset();
    vid_req = 1; vid_addr = 22'h00ABCD;
    cpu_req = 1; cpu_we = 1; cpu_addr = 22'h0003C0; cpu_wdata = 16'h5A5A;
    cpu_lb_n = 0; cpu_ub_n = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_we_n, vid_ack, cpu_ack, cpu_rvalid} !== {(k == 3), (k != 10), (k == 3), (k == 10), 1'b0}) begin
        errors++; $display("FAIL vid_cpu strobes cyc %0d: got rd,we_n,vack,cack,crv %b", k, {mem_rd, mem_we_n, vid_ack, cpu_ack, cpu_rvalid});
      end
      if (k == 3) begin
        checks++;
        if ({mem_addr, mem_lb_n, mem_ub_n} !== {22'h00ABCD, 2'b00}) begin
          errors++; $display("FAIL vid_cpu vid_cmd: got addr %h be_n %b%b expected 00abcd 00", mem_addr, mem_lb_n, mem_ub_n);
        end
        vid_req = 0;
      end
      if (k == 10) begin
        checks++;
        if ({mem_addr, mem_wdata, mem_lb_n, mem_ub_n} !== {22'h0003C0, 16'h5A5A, 2'b01}) begin
          errors++; $display("FAIL vid_cpu cpu_wr: got addr %h wdata %h lb_n %b ub_n %b expected 0003c0 5a5a 0 1", mem_addr, mem_wdata, mem_lb_n, mem_ub_n);
        end
        checks++;
        if (vid_rvalid !== 1'b1 || vid_rdata !== 16'h1401) begin
          errors++; $display("FAIL vid_cpu vid_return: got rvalid %b rdata %h expected 1 1401", vid_rvalid, vid_rdata);
        end
        cpu_req = 0;
      end
      if (k == 12) begin
        checks++;
        if (mem_wdata !== 16'h5A5A || mem_addr !== 22'h0003C0) begin
          errors++; $display("FAIL vid_cpu hold: got addr %h wdata %h expected 0003c0 5a5a", mem_addr, mem_wdata);
        end
      end
    end
  endtask

  task automatic test_cpu_aux_priority();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000200;
    aux_req = 1; aux_we = 0; aux_addr = 22'h2A0010;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd, cpu_ack, aux_ack, cpu_rvalid, aux_rvalid} !== {(k == 3 || k == 10), (k == 3), (k == 10), (k == 10), (k == 17)}) begin
        errors++; $display("FAIL cpu_aux strobes cyc %0d: got rd,cack,aack,crv,arv %b", k, {mem_rd, cpu_ack, aux_ack, cpu_rvalid, aux_rvalid});
      end
      if (k == 3) cpu_req = 0;
      if (k == 10) begin
        checks++;
        if (mem_addr !== 22'h2A0010 || cpu_rdata !== 16'hBDCC) begin
          errors++; $display("FAIL cpu_aux cyc10: got addr %h cpu_rdata %h expected 2a0010 bdcc", mem_addr, cpu_rdata);
        end
        aux_req = 0;
      end
      if (k == 17) begin
        checks++;
        if (aux_rdata !== 16'hBFDC || cpu_rdata !== 16'hBDCC) begin
          errors++; $display("FAIL cpu_aux aux_return: got aux %h cpu %h expected bfdc bdcc", aux_rdata, cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_aux_withdraw();
    do_reset();
    aux_req = 1; aux_we = 1; aux_addr = 22'h3FFFFF; aux_wdata = 16'h1234;
    aux_lb_n = 1; aux_ub_n = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        checks++;
        if ({mem_rd, mem_we_n, aux_ack} !== 3'b010) begin
          errors++; $display("FAIL aux_withdraw idle cyc %0d: got rd,we_n,ack %b expected 010", k, {mem_rd, mem_we_n, aux_ack});
        end
      end else begin
        checks++;
        if ({mem_we_n, aux_ack, mem_addr, mem_wdata, mem_lb_n, mem_ub_n} !== {2'b01, 22'h3FFFFF, 16'h1234, 2'b10}) begin
          errors++; $display("FAIL aux_withdraw late_wr: got we_n %b ack %b addr %h wdata %h lb_n %b ub_n %b expected 0 1 3fffff 1234 1 0", mem_we_n, aux_ack, mem_addr, mem_wdata, mem_lb_n, mem_ub_n);
        end
        aux_req = 0;
      end
      if (k == 1) aux_req = 0;
      if (k == 12) aux_req = 1;
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000123;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rd !== (k == 3 || k == 8)) begin
        errors++; $display("FAIL reset_mid mem_rd cyc %0d: got %b expected %b", k, mem_rd, (k == 3 || k == 8));
      end
      checks++;
      if (cpu_rvalid !== (k == 15)) begin
        errors++; $display("FAIL reset_mid rvalid cyc %0d: got %b expected %b", k, cpu_rvalid, (k == 15));
      end
      if (k == 3) cpu_req = 0;
      if (k == 4) reset = 1;
      if (k == 5) begin
        checks++;
        if ({mem_rd, mem_we_n, mem_refresh, mem_lb_n, mem_ub_n, cpu_ack, cpu_rvalid} !== 7'b0101100 || mem_addr !== 22'h0 || mem_wdata !== 16'h0) begin
          errors++; $display("FAIL reset_mid values: got strobes %b addr %h wdata %h", {mem_rd, mem_we_n, mem_refresh, mem_lb_n, mem_ub_n, cpu_ack, cpu_rvalid}, mem_addr, mem_wdata);
        end
        reset = 0;
        cpu_req = 1; cpu_addr = 22'h000456;
      end
      if (k == 8) cpu_req = 0;
      if (k == 15) begin
        checks++;
        if (cpu_rdata !== 16'hBB9A) begin
          errors++; $display("FAIL reset_mid rdata: got %h expected bb9a", cpu_rdata);
        end
      end
    end
  endtask

`ifdef SDRAM_ARB_REFRESH_EN
  task automatic test_refresh_stream();
    logic exp_rd;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000777;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      exp_rd = (k >= 3 && k <= 66 && ((k - 3) % 7) == 0) || (k >= 83 && ((k - 83) % 7) == 0);
      checks++;
      if ({mem_rd, mem_refresh} !== {exp_rd, (k == 73)}) begin
        errors++; $display("FAIL refresh_stream cyc %0d: got rd %b ref %b expected %b %b", k, mem_rd, mem_refresh, exp_rd, (k == 73));
      end
    end
    cpu_req = 0;
  endtask

  task automatic test_refresh_idle();
    do_reset();
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_refresh} !== {1'b0, (k >= 51 && ((k - 51) % 50) == 0)}) begin
        errors++; $display("FAIL refresh_idle cyc %0d: got rd %b ref %b", k, mem_rd, mem_refresh);
      end
    end
  endtask
`else
  task automatic test_no_refresh();
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_we_n, mem_refresh} !== 3'b010) begin
        errors++; $display("FAIL no_refresh cyc %0d: got rd,we_n,ref %b expected 010", k, {mem_rd, mem_we_n, mem_refresh});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_vid_cpu_priority();
    test_cpu_aux_priority();
    test_aux_withdraw();
    test_reset_mid_read();
`ifdef SDRAM_ARB_REFRESH_EN
    test_refresh_stream();
    test_refresh_idle();
`else
    test_no_refresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter and command sequencer in front of the single-bank-cycle SDRAM controller. It shares one SDRAM between the video fetcher, the CPU and an auxiliary port (tape/DMA), and generates periodic refresh. It issues exactly one single-cycle command per controller idle window and tracks controller occupancy with fixed cycle counts rather than `membusy`. It sits between the bus/video logic and the SDRAM controller in the memory subsystem.

## Interface
Parameters:
- `BUSY_RW`, 6: cycles from command cycle until the controller is idle again after a read or write.
- `BUSY_REF`, 9: cycles from the refresh strobe cycle until the controller is idle again.
- `RD_LAT`, 6: cycles from the read command cycle until `mem_datar` is valid.
- `INIT_WAIT`, 2: cycles after reset release before the first command.
- `REF_PERIOD`, 1350: cycles between refresh requests (15 µs at 90 MHz).
- `REF_URGENT`, 1200: cycles a refresh may stay pending before it overrides all ports.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `vid_req`  in  1  video read request; held until ack.
- `vid_addr`  in  22  video word address.
- `vid_ack`, `vid_rvalid`  out  1  command-accepted pulse; read-data-valid pulse.
- `vid_rdata`  out  16  video read data.
- `cpu_req`, `cpu_we`  in  1  request; 1 = write, 0 = read.
- `cpu_addr`  in  22  word address.
- `cpu_wdata`  in  16  write data.
- `cpu_lb_n`, `cpu_ub_n`  in  1  byte enables, active-low.
- `cpu_ack`, `cpu_rvalid`  out  1  as for video.
- `cpu_rdata`  out  16  read data.
- `aux_*`  same set as `cpu_*`.
- `mem_addr`  out  22  to controller `iaddr`.
- `mem_wdata`  out  16  to controller `dataw`.
- `mem_rd`  out  1  read strobe.
- `mem_we_n`  out  1  write strobe, active-low.
- `mem_lb_n`, `mem_ub_n`  out  1  byte enables.
- `mem_refresh`  out  1  refresh strobe.
- `mem_datar`  in  16  controller read data.

## Operation
- States: `A_INIT`, `A_IDLE`, `A_CMD`, `A_WAIT`.
- `A_INIT`: wait `INIT_WAIT` cycles, then go to `A_IDLE`.
- `A_IDLE`: pick one winner. Priority order: urgent refresh > video > CPU > aux > pending refresh. Register the command outputs and go to `A_CMD`. If there is no winner, stay in `A_IDLE`.
- `A_CMD`: lasts one cycle.
  - Exactly one of `mem_rd`, `~mem_we_n` or `mem_refresh` is active, and the winner's `*_ack` pulses.
  - The busy counter loads `BUSY_RW-1` or `BUSY_REF-1`, then the state goes to `A_WAIT`.
- `A_WAIT`: decrement the counter; at 0 go to `A_IDLE`.
- Video is read-only: `mem_lb_n` = `mem_ub_n` = 0.
- Read return: a 3-bit owner tag and a latency counter are loaded at `A_CMD`. When `RD_LAT` cycles have elapsed, capture `mem_datar` into the owner's `*_rdata` and pulse its `*_rvalid` one cycle later. Only one read is ever outstanding because `RD_LAT` ≤ `BUSY_RW`.
- Refresh timer:
  - Counts up to `REF_PERIOD-1`, then sets `ref_pending` and wraps to 0.
  - The pending age counter saturates. Age ≥ `REF_URGENT` makes the refresh urgent.
  - `ref_pending` clears in the refresh `A_CMD` cycle.
  - A new period expiry while already pending is dropped; there is no second refresh queued.
- Writes: `mem_wdata`/`mem_addr`/byte enables are registered from the winner and held unchanged until the next command.
- Requesters must hold `req` and payload stable until `ack`. Dropping `req` before `ack` withdraws the request, with no side effects.

## Timing
- Request seen in `A_IDLE` at cycle t: command strobe and `ack` in cycle t+1 (= c).
- Read data: `*_rvalid` in cycle c+`RD_LAT`+1 (c+7 default).
- Next command earliest at c+`BUSY_RW`+1 for read/write, or c+`BUSY_REF`+1 for refresh.
- Back-to-back CPU reads therefore issue every 7 cycles.
- Reset values:
  - `mem_rd`=0, `mem_we_n`=1, `mem_refresh`=0, `mem_lb_n`=`mem_ub_n`=1.
  - `mem_addr`=0, `mem_wdata`=0.
  - All `*_ack`/`*_rvalid`=0, all `*_rdata`=0.
  - Refresh timer=0, `ref_pending`=0, state `A_INIT`.
- Reset mid-operation: all state is abandoned. The outstanding read produces no `rvalid`, and the `A_INIT` wait restarts.
- Simultaneous events: a request and refresh expiry in the same cycle are resolved by the priority order above. The expiry still sets `ref_pending`.

## Configuration
- `SDRAM_ARB_REFRESH_EN` defined: internal refresh timer, pending/urgent logic and refresh grants are present.
- `SDRAM_ARB_REFRESH_EN` undefined:
  - `mem_refresh` is tied to 0, and the `REF_*` parameters are unused.
  - Only video/CPU/aux are arbitrated; refresh is the system's responsibility elsewhere.

## Structure
- Package `sdram_arb_pkg`:
  - State enum (`A_INIT`..`A_WAIT`).
  - Owner tag constants (`OWN_NONE`, `OWN_VID`, `OWN_CPU`, `OWN_AUX`, `OWN_REF`).
  - Default latency constants.
- Sub-module `sdram_refresh_timer`: period counter, pending flag, age/urgent flag, `clear` input. Instantiated only under `SDRAM_ARB_REFRESH_EN`.

## Test plan
- Reset, then hold `cpu_req` read at addr 0x000123: first `mem_rd` at cycle `INIT_WAIT`+1 after reset release, one cycle wide, `mem_addr`=0x000123; `cpu_rvalid` 7 cycles later with `cpu_rdata` = model data 0xBEEF.
- `vid_req` and `cpu_req` write asserted in the same cycle: video read issued first; the CPU write (`mem_we_n`=0, `mem_wdata`=0x5A5A, `mem_ub_n`=1, `mem_lb_n`=0) issued exactly 7 cycles later.
- CPU streams reads continuously with `REF_PERIOD`=50, `REF_URGENT`=20: after expiry, refresh is granted only once pending age ≥ 20. `mem_refresh` is one cycle wide, and the next CPU command comes 10 cycles after it.
- Idle ports, `REF_PERIOD`=50: `mem_refresh` pulses every 50 cycles, never two within 9 cycles.
- Assert `reset` in the cycle after a read `ack`: no `rvalid` is produced, and all outputs show reset values on the next cycle.
- `aux_req` dropped one cycle before it would win: no command, no `aux_ack`, and the arbiter stays in `A_IDLE`.
